awg_sequencer: RTL and testbench

//  Controller for the 8-bit PMOD AWG output path. It divides ref_clk into a sample strobe and steps a

---
 rtl/awg_sequencer.sv | 163 ++++++++++++++++
 tb/tb_awg_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_sequencer.sv
// Sample sequencer for the 8-bit PMOD AWG: divides ref_clk into sample strobes,
// walks one waveform period per pass and runs finite or continuous bursts.
module awg_sequencer #(
    parameter int CLK_DIV   = 4,
    parameter int N_SAMPLES = 15,
    parameter int BURST_W   = 8,
    localparam int IDX_W    = $clog2(N_SAMPLES)
) (
    input  logic               ref_clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         wave_sel,
    input  logic [BURST_W-1:0] burst_len,
    output logic [IDX_W-1:0]   lut_addr,
    input  logic [7:0]         lut_data,
    output logic [7:0]         pmod,
    output logic               sample_valid,
    output logic               period_tick,
    output logic               busy,
    output logic               done
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t             state_q;
    logic [1:0]         wave_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] per_q;
    logic [DIV_W-1:0]   div_q;
    logic [IDX_W-1:0]   idx_q;
    logic               pend_q;
    logic               tick_q;
    logic               last_q;
    logic [7:0]         shape_q;
    logic [7:0]         shape_d;
    logic [7:0]         pmod_q;
    logic               valid_q;
    logic               ptick_q;
    logic               done_q;
    logic               strobe;
    logic               wrap;

    function automatic logic [7:0] shape(input logic [1:0] sel,
                                         input logic [IDX_W-1:0] k);
        logic [15:0] kk;
        logic [15:0] n;
        logic [15:0] v;
        kk = 16'(k);
        n  = 16'(N_SAMPLES);
        v  = 16'd0;
        unique case (sel)
            2'd0: v = (kk * 16'd256) / n;
            2'd1: begin
                if (kk < n / 16'd2) v = (16'd2 * kk * 16'd256) / n;
                else                v = (16'd2 * (n - kk) * 16'd256) / n;
            end
            2'd2: v = (kk < n / 16'd2) ? 16'd255 : 16'd0;
            2'd3: v = 16'd0;
        endcase
        return (v > 16'd255) ? 8'd255 : v[7:0];
    endfunction

    always_comb begin
        shape_d = shape(wave_q, idx_q);
    end

    assign strobe       = (div_q == '0);
    assign wrap         = (idx_q == IDX_LAST);
    assign lut_addr     = idx_q;
    assign pmod         = pmod_q;
    assign sample_valid = valid_q;
    assign period_tick  = ptick_q;
    assign done         = done_q;
    assign busy         = (state_q != S_IDLE);

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wave_q  <= 2'd0;
            burst_q <= '0;
            per_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            tick_q  <= 1'b0;
            last_q  <= 1'b0;
            shape_q <= 8'd0;
            pmod_q  <= 8'd128;
            valid_q <= 1'b0;
            ptick_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ptick_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_q <= S_RUN;
                        wave_q  <= wave_sel;
                        burst_q <= burst_len;
                        per_q   <= '0;
                        div_q   <= '0;
                        idx_q   <= '0;
                        pend_q  <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        pend_q  <= 1'b0;
                    end else begin
                        div_q  <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                        pend_q <= strobe;
                        // Emit the sample captured on the previous strobe edge.
                        if (pend_q) begin
                            pmod_q  <= (wave_q == 2'd3) ? lut_data : shape_q;
                            valid_q <= 1'b1;
                            ptick_q <= tick_q;
                        end
                        if (strobe) begin
                            shape_q <= shape_d;
                            tick_q  <= wrap;
                            if (wrap) begin
                                idx_q <= '0;
                                per_q <= per_q + BURST_W'(1);
                                if (burst_q != '0 &&
                                    per_q == burst_q - BURST_W'(1)) begin
                                    last_q  <= 1'b1;
                                    state_q <= S_DRAIN;
                                end
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stop) begin
                        pmod_q  <= (wave_q == 2'd3) ? lut_data : shape_q;
                        valid_q <= 1'b1;
                        ptick_q <= tick_q;
                        done_q  <= last_q;
                    end
                    state_q <= S_IDLE;
                    pend_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_awg_sequencer.sv
// Randomized self-checking bench for awg_sequencer; expected outputs are
// derived per edge from sample timing arithmetic, not from the RTL structure.
module tb_awg_sequencer;

    localparam int N  = 15;
    localparam int CD = 4;

    logic       ref_clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] wave_sel;
    logic [7:0] burst_len;
    logic [3:0] lut_addr;
    logic [7:0] lut_data;
    logic [7:0] pmod;
    logic       sample_valid;
    logic       period_tick;
    logic       busy;
    logic       done;

    logic [7:0] lut_mem [16];
    logic [7:0] exp_pmod;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       sv;
        logic       tick;
        logic       done;
        logic       busy;
        logic [7:0] val;
    } exp_t;

    always #5 ref_clk = ~ref_clk;

    always @(posedge ref_clk) lut_data <= lut_mem[lut_addr];

    awg_sequencer dut (
        .ref_clk(ref_clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .wave_sel(wave_sel),
        .burst_len(burst_len),
        .lut_addr(lut_addr),
        .lut_data(lut_data),
        .pmod(pmod),
        .sample_valid(sample_valid),
        .period_tick(period_tick),
        .busy(busy),
        .done(done)
    );

    function automatic logic [7:0] ref_shape(input int w, input int k);
        int v;
        case (w)
            0: v = (k * 256) / N;
            1: v = (k < N / 2) ? (2 * k * 256) / N : (2 * (N - k) * 256) / N;
            2: v = (k < N / 2) ? 255 : 0;
            default: v = lut_mem[k];
        endcase
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    // Edge t counts from the edge that accepts start (t=0).
    // Sample j leaves the block on edge 2 + CD*j.
    function automatic exp_t model(input int t, input int w, input int len);
        exp_t e;
        int total;
        int j;
        e = '0;
        total = len * N;
        j = (t - 2) / CD;
        e.sv = (t >= 2) && ((t - 2) % CD == 0) && (len == 0 || j < total);
        if (e.sv) begin
            e.val  = ref_shape(w, j % N);
            e.tick = (j % N == N - 1);
            e.done = (len != 0) && (j == total - 1);
        end
        e.busy = (len == 0) || (t < 2 + CD * (total - 1));
        return e;
    endfunction

    task automatic test_reset();
        @(posedge ref_clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (pmod !== 8'd128 || busy !== 1'b0 || sample_valid !== 1'b0 ||
            period_tick !== 1'b0 || done !== 1'b0 || lut_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset: pmod=%0d busy=%b sv=%b tick=%b done=%b addr=%0d, want 128 0 0 0 0 0",
                     pmod, busy, sample_valid, period_tick, done, lut_addr);
        end
        @(posedge ref_clk);
        #1 rst = 1'b1;
        exp_pmod = 8'd128;
        repeat (6) begin
            @(posedge ref_clk);
            #1;
            checks++;
            if (busy !== 1'b0 || sample_valid !== 1'b0 || pmod !== 8'd128) begin
                errors++;
                $display("FAIL reset_idle: busy=%b sv=%b pmod=%0d, want 0 0 128",
                         busy, sample_valid, pmod);
            end
        end
    endtask

    // ign_at: edge on which a competing start (other config) is presented.
    task automatic test_burst(input int w, input int len, input int ncyc,
                              input int ign_at);
        exp_t e;
        wave_sel  = 2'(w);
        burst_len = 8'(len);
        start     = 1'b1;
        for (int t = 0; t <= ncyc; t++) begin
            @(posedge ref_clk);
            #1;
            start = (t + 1 == ign_at);
            if (start) begin
                wave_sel  = ~2'(w);
                burst_len = 8'd5;
            end
            e = model(t, w, len);
            if (e.sv) exp_pmod = e.val;
            checks++;
            if (sample_valid !== e.sv || pmod !== exp_pmod ||
                period_tick !== e.tick || done !== e.done || busy !== e.busy) begin
                errors++;
                $display("FAIL burst w=%0d len=%0d t=%0d: sv=%b pmod=%0d tick=%b done=%b busy=%b want %b %0d %b %b %b",
                         w, len, t, sample_valid, pmod, period_tick, done, busy,
                         e.sv, exp_pmod, e.tick, e.done, e.busy);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_lut_stop();
        exp_t e;
        int m;
        int ncyc;
        logic [3:0] exp_addr;
        m = $urandom_range(15, 25);
        ncyc = CD * m + 1;
        wave_sel  = 2'd3;
        burst_len = 8'd0;
        start     = 1'b1;
        for (int t = 0; t <= ncyc; t++) begin
            @(posedge ref_clk);
            #1 start = 1'b0;
            e = model(t, 3, 0);
            if (e.sv) exp_pmod = e.val;
            exp_addr = (t == 0) ? 4'd0 : 4'(((t - 1) / CD + 1) % N);
            checks++;
            if (sample_valid !== e.sv || pmod !== exp_pmod ||
                period_tick !== e.tick || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL lut t=%0d: sv=%b pmod=%0d tick=%b done=%b busy=%b want %b %0d %b 0 1",
                         t, sample_valid, pmod, period_tick, done, busy,
                         e.sv, exp_pmod, e.tick);
            end
            checks++;
            if (lut_addr !== exp_addr) begin
                errors++;
                $display("FAIL lut_addr t=%0d: got %0d want %0d", t, lut_addr, exp_addr);
            end
        end
        // Stop lands on an edge that would otherwise emit a sample.
        stop = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(posedge ref_clk);
            #1 stop = 1'b0;
            checks++;
            if (sample_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
                period_tick !== 1'b0 || pmod !== exp_pmod) begin
                errors++;
                $display("FAIL stop t=%0d: sv=%b busy=%b done=%b tick=%b pmod=%0d want 0 0 0 0 %0d",
                         t, sample_valid, busy, done, period_tick, pmod, exp_pmod);
            end
        end
    endtask

    task automatic test_idle_start_stop();
        start    = 1'b1;
        stop     = 1'b1;
        wave_sel = 2'd0;
        burst_len = 8'd1;
        for (int t = 0; t < 10; t++) begin
            @(posedge ref_clk);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            checks++;
            if (busy !== 1'b0 || sample_valid !== 1'b0 || pmod !== exp_pmod) begin
                errors++;
                $display("FAIL start_stop t=%0d: busy=%b sv=%b pmod=%0d want 0 0 %0d",
                         t, busy, sample_valid, pmod, exp_pmod);
            end
        end
    endtask

    task automatic test_random_bursts();
        int w;
        int len;
        for (int i = 0; i < 16; i++) lut_mem[i] = 8'($urandom);
        repeat (4) begin
            w   = $urandom_range(0, 3);
            len = $urandom_range(1, 3);
            test_burst(w, len, CD * len * N + 6, -1);
        end
    endtask

    task automatic test_reset_midburst();
        wave_sel  = 2'd0;
        burst_len = 8'd2;
        start     = 1'b1;
        @(posedge ref_clk);
        #1 start = 1'b0;
        repeat ($urandom_range(20, 50)) @(posedge ref_clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (pmod !== 8'd128 || busy !== 1'b0 || sample_valid !== 1'b0 ||
            done !== 1'b0 || lut_addr !== 4'd0) begin
            errors++;
            $display("FAIL midreset: pmod=%0d busy=%b sv=%b done=%b addr=%0d want 128 0 0 0 0",
                     pmod, busy, sample_valid, done, lut_addr);
        end
        @(posedge ref_clk);
        #1 rst = 1'b1;
        repeat (80) begin
            @(posedge ref_clk);
            #1;
            checks++;
            if (busy !== 1'b0 || sample_valid !== 1'b0 || done !== 1'b0 ||
                pmod !== 8'd128) begin
                errors++;
                $display("FAIL midreset_idle: busy=%b sv=%b done=%b pmod=%0d want 0 0 0 128",
                         busy, sample_valid, done, pmod);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        wave_sel  = 2'd0;
        burst_len = 8'd0;
        exp_pmod  = 8'd128;
        for (int i = 0; i < 16; i++) lut_mem[i] = 8'(i * 10);
        test_reset();
        test_burst(0, 1, CD * N + 6, -1);
        test_burst(2, 2, 2 * CD * N + 6, -1);
        test_lut_stop();
        test_burst(1, 1, CD * N + 6, 20);
        test_idle_start_stop();
        test_random_bursts();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
